xbar_switch: RTL and testbench
==============================

# xbar_switch

Parametrised wormhole crossbar for the router switch-traversal stage. It connects `NUM_PORTS` input buffers to `NUM_PORTS` output links, with round-robin arbitration per output and an output lock held from head flit to tail flit. Each output has a registered valid/ready stage. It replaces the fixed 5-port switch and adds backpressure, fair arbitration, single-flit packets and invalid-target drop.

## Interface
- `NUM_PORTS`, 5: number of input and output ports (2..16).
- `FLIT_W`, 64: flit payload width in bits.
- `PORT_W`, `$clog2(NUM_PORTS)`: width of the target-port index (derived).
- `clk` input 1: single clock; all state on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input [NUM_PORTS]: input i presents a flit.
- `in_flit` input [NUM_PORTS][FLIT_W]: flit payload.
- `in_head` input [NUM_PORTS]: flit is the head of a packet.
- `in_tail` input [NUM_PORTS]: flit is the tail (head and tail together = single-flit packet).
- `in_target` input [NUM_PORTS][PORT_W]: requested output; sampled only on a head flit.
- `in_ready` output [NUM_PORTS]: flit accepted when `in_valid && in_ready`.
- `out_valid` output [NUM_PORTS]: output register holds a flit.
- `out_flit` output [NUM_PORTS][FLIT_W]: registered payload.
- `out_tail` output [NUM_PORTS]: registered tail flag.
- `out_ready` input [NUM_PORTS]: downstream accepts when `out_valid && out_ready`.
- `err_drop` output [NUM_PORTS]: one-cycle pulse when input i's head carries `in_target >= NUM_PORTS`.

## Operation
- Per output o: `lock_v[o]` and `lock_src[o]` (the owning input); per input i: `bound_v[i]` and `bound_dst[i]`.
- Output o can load when `!out_valid[o] || out_ready[o]`.
- Request: input i requests o when `in_valid[i] && in_head[i] && !bound_v[i] && in_target[i]==o && !lock_v[o]`.
- Arbitration: when o is unlocked and can load, a round-robin arbiter grants one requester. The grant and the head transfer happen in the same cycle. The pointer moves to grantee+1 (mod `NUM_PORTS`) only on an actual transfer.
- Head transfer without tail: set `lock_v[o]`, `lock_src[o]=i`, `bound_v[i]`, `bound_dst[i]=o`.
- Body and tail flits: `in_ready[i] = bound_v[i] && can_load[bound_dst[i]]`. A flit presented with `in_head` while bound is a protocol error; it is forwarded as body.
- Tail transfer clears the lock and binding in that cycle's update. The output can be re-granted on the next cycle.
- Head with tail (single-flit packet): forwarded; no lock is set.
- Invalid target: the head is accepted (`in_ready=1`) and discarded, `err_drop[i]` pulses, and no lock or binding is set.
- No flit is ever dropped or duplicated on a valid path. Per-packet flit order is preserved.

## Timing
- Reset values: `out_valid=0`, `out_flit=0`, `out_tail=0`, `in_ready=0`, `err_drop=0`, all locks and bindings clear, all pointers 0.
- Latency: a flit transferred in cycle N appears on `out_valid/out_flit` in cycle N+1.
- Throughput: 1 flit/cycle per output while `out_ready` stays high. With `out_ready=0`, the register holds and `in_ready` of the owner drops in the same cycle.
- `in_ready` is combinational from `in_valid`, `in_head`, `in_target` and `out_ready`. `out_*` are registered only.
- Simultaneous tail on o and new head for o: the head is granted no earlier than the next cycle.
- Reset mid-packet clears all locks; any partial packet is discarded by the reset.

## Configuration
- `XBAR_STATS_EN` defined: adds `stat_flits` output [NUM_PORTS][16], one counter per output. It counts output transfers, saturates at 0xFFFF and resets to 0.
- `XBAR_STATS_EN` undefined: no port, no counters; all other behaviour is identical.

## Structure
- Shared package: `PORT_W` function/localparam, the `xbar_lock_t` struct `{valid, src}`, and the `NONE_PORT` constant. The `in_*` bundle fields move into `router_pipeline_bus_t`.
- Sub-module: `rr_arbiter` (parameter `N`; ports `clk`, `rst`, `req[N]`, `advance`, `grant[N]` one-hot). Instantiate one per output.

## Test plan
- 3-flit packet in0→o2, `out_ready=1`: out_valid[2] high cycles 2–4 with flits in order; lock_v[2] clears after the tail.
- in0 and in1 both heads to o3 each cycle, 1-flit packets: grants alternate 0,1,0,1; no starvation over 20 packets.
- out_ready[1]=0 for 4 cycles mid-packet: out_flit[1] held, in_ready of the owner is 0, no flit lost; resumes in order.
- Head with in_target=7 at NUM_PORTS=5: in_ready=1, err_drop pulses 1 cycle, no out_valid anywhere.
- Five inputs to five distinct outputs simultaneously: all accepted in the same cycle and all out_valid high the next cycle.
- rst asserted mid-packet: all outputs 0 immediately; after release, a new head to the same output is granted.

Source files
------------

// File: rtl/xbar_switch_pkg.sv
// Shared types and constants for the wormhole crossbar switch.
package xbar_switch_pkg;

    localparam int MAX_PORT_W = 4;
    localparam logic [MAX_PORT_W-1:0] NONE_PORT = '1;

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [MAX_PORT_W-1:0] src;
    } xbar_lock_t;

    // Per-input control fields, target zero-extended to the widest port index.
    typedef struct packed {
        logic                  valid;
        logic                  head;
        logic                  tail;
        logic [MAX_PORT_W-1:0] target;
    } router_pipeline_bus_t;

endpackage

// File: rtl/xbar_switch_arbiter.sv
// Round-robin arbiter: highest priority starts at the pointer, which moves past the grantee on advance.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    int            idx;

    // Scan from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[IW'(idx)]) begin
                grant            = '0;
                grant[IW'(idx)]  = 1'b1;
                grant_idx        = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/xbar_switch.sv
// Wormhole crossbar: round-robin per output, lock head-to-tail, registered valid/ready outputs.
// Optional per-output flit counters when XBAR_STATS_EN is defined.
module xbar_switch
    import xbar_switch_pkg::*;
#(
    parameter  int NUM_PORTS = 5,
    parameter  int FLIT_W    = 64,
    localparam int PORT_W    = port_w(NUM_PORTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                in_valid,
    input  logic [NUM_PORTS-1:0][FLIT_W-1:0]    in_flit,
    input  logic [NUM_PORTS-1:0]                in_head,
    input  logic [NUM_PORTS-1:0]                in_tail,
    input  logic [NUM_PORTS-1:0][PORT_W-1:0]    in_target,
    output logic [NUM_PORTS-1:0]                in_ready,
    output logic [NUM_PORTS-1:0]                out_valid,
    output logic [NUM_PORTS-1:0][FLIT_W-1:0]    out_flit,
    output logic [NUM_PORTS-1:0]                out_tail,
    input  logic [NUM_PORTS-1:0]                out_ready,
    output logic [NUM_PORTS-1:0]                err_drop
`ifdef XBAR_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][15:0]          stat_flits
`endif
);

    router_pipeline_bus_t   bus       [NUM_PORTS];
    xbar_lock_t             lock      [NUM_PORTS];
    logic [MAX_PORT_W-1:0]  bound_dst [NUM_PORTS];
    logic [NUM_PORTS-1:0]   req       [NUM_PORTS];
    logic [NUM_PORTS-1:0]   grant     [NUM_PORTS];
    logic [FLIT_W-1:0]      load_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0]   bound_v;
    logic [NUM_PORTS-1:0]   can_load;
    logic [NUM_PORTS-1:0]   tgt_ok;
    logic [NUM_PORTS-1:0]   head_req;
    logic [NUM_PORTS-1:0]   accept;
    logic [NUM_PORTS-1:0]   advance;
    logic [NUM_PORTS-1:0]   load;
    logic [NUM_PORTS-1:0]   load_tail;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus[i]      = '{valid: in_valid[i], head: in_head[i], tail: in_tail[i],
                            target: MAX_PORT_W'(in_target[i])};
            tgt_ok[i]   = int'(bus[i].target) < NUM_PORTS;
            head_req[i] = bus[i].valid && bus[i].head && !bound_v[i];
            can_load[i] = !out_valid[i] || out_ready[i];
        end
    end

    // Only unlocked outputs that can load this cycle see requests, so a grant is always a transfer.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = head_req[i] && tgt_ok[i] && (bus[i].target == MAX_PORT_W'(o))
                            && !lock[o].valid && can_load[o];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (req[o]),
            .advance (advance[o]),
            .grant   (grant[o])
        );
        assign advance[o] = |grant[o];
    end

    always_comb begin
        in_ready = '0;
        err_drop = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bound_v[i]) begin
                    for (int o = 0; o < NUM_PORTS; o++) begin
                        if (bound_dst[i] == MAX_PORT_W'(o) && lock[o].valid
                            && lock[o].src == MAX_PORT_W'(i))
                            in_ready[i] = can_load[o];
                    end
                end else if (head_req[i] && !tgt_ok[i]) begin
                    in_ready[i] = 1'b1;
                    err_drop[i] = 1'b1;
                end else if (head_req[i]) begin
                    for (int o = 0; o < NUM_PORTS; o++) begin
                        if (grant[o][i]) in_ready[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign accept = in_valid & in_ready;

    // Each output takes at most one flit: from its lock owner, or from this cycle's grantee.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            load[o]      = 1'b0;
            load_tail[o] = 1'b0;
            load_flit[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (accept[i] && ((lock[o].valid && lock[o].src == MAX_PORT_W'(i)) || grant[o][i])) begin
                    load[o]      = 1'b1;
                    load_tail[o] = bus[i].tail;
                    load_flit[o] = in_flit[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bound_v <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                bound_dst[i] <= NONE_PORT;
                lock[i]      <= '{valid: 1'b0, src: NONE_PORT};
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (accept[i] && bound_v[i] && bus[i].tail) begin
                    bound_v[i] <= 1'b0;
                    for (int o = 0; o < NUM_PORTS; o++) begin
                        if (bound_dst[i] == MAX_PORT_W'(o)) lock[o].valid <= 1'b0;
                    end
                end else if (accept[i] && !bound_v[i] && tgt_ok[i] && !bus[i].tail) begin
                    bound_v[i]   <= 1'b1;
                    bound_dst[i] <= bus[i].target;
                    for (int o = 0; o < NUM_PORTS; o++) begin
                        if (bus[i].target == MAX_PORT_W'(o))
                            lock[o] <= '{valid: 1'b1, src: MAX_PORT_W'(i)};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_tail  <= '0;
            out_flit  <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (load[o]) begin
                    out_valid[o] <= 1'b1;
                    out_tail[o]  <= load_tail[o];
                    out_flit[o]  <= load_flit[o];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef XBAR_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flits <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (out_valid[o] && out_ready[o] && stat_flits[o] != 16'hFFFF)
                    stat_flits[o] <= stat_flits[o] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbar_switch.sv
// Directed bench for xbar_switch with a cycle-level reference model and literal spot checks.
module tb_xbar_switch;
    localparam int NP = 5;
    localparam int FW = 64;

    logic                    clk;
    logic                    rst;
    logic [NP-1:0]           in_valid;
    logic [NP-1:0][FW-1:0]   in_flit;
    logic [NP-1:0]           in_head;
    logic [NP-1:0]           in_tail;
    logic [NP-1:0][2:0]      in_target;
    logic [NP-1:0]           in_ready;
    logic [NP-1:0]           out_valid;
    logic [NP-1:0][FW-1:0]   out_flit;
    logic [NP-1:0]           out_tail;
    logic [NP-1:0]           out_ready;
    logic [NP-1:0]           err_drop;

    int n_vec  = 0;
    int n_fail = 0;

    xbar_switch #(.NUM_PORTS(NP), .FLIT_W(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_head   (in_head),
        .in_tail   (in_tail),
        .in_target (in_target),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_tail  (out_tail),
        .out_ready (out_ready),
        .err_drop  (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner per output, packet binding per input, round-robin pointer per output.
    int               m_own  [NP];
    int               m_bind [NP];
    int               m_ptr  [NP];
    int               m_dst  [NP];
    logic [NP-1:0]    m_ov, m_ot, m_rdy, m_drop, canl;
    logic [63:0]      m_of   [NP];

    always @(negedge clk) begin
        int t;
        int w;
        int j;
        for (int o = 0; o < NP; o++) canl[o] = !m_ov[o] || out_ready[o];
        m_rdy  = '0;
        m_drop = '0;
        for (int i = 0; i < NP; i++) m_dst[i] = -1;
        if (!rst) begin
            for (int i = 0; i < NP; i++) begin
                if (m_bind[i] >= 0) begin
                    m_rdy[i] = canl[m_bind[i]];
                    m_dst[i] = m_bind[i];
                end else if (in_valid[i] && in_head[i]) begin
                    t = int'(in_target[i]);
                    if (t >= NP) begin
                        m_rdy[i]  = 1'b1;
                        m_drop[i] = 1'b1;
                    end else if (m_own[t] < 0 && canl[t]) begin
                        w = -1;
                        for (int k = 0; k < NP; k++) begin
                            j = (m_ptr[t] + k) % NP;
                            if (w < 0 && in_valid[j] && in_head[j] && m_bind[j] < 0
                                && int'(in_target[j]) == t) w = j;
                        end
                        if (w == i) begin
                            m_rdy[i] = 1'b1;
                            m_dst[i] = t;
                        end
                    end
                end
            end
        end
        check_output("model in_ready", 64'(in_ready), 64'(m_rdy));
        check_output("model err_drop", 64'(err_drop), 64'(m_drop));
        check_output("model out_valid", 64'(out_valid), 64'(m_ov));
        for (int o = 0; o < NP; o++) begin
            if (m_ov[o]) begin
                check_output($sformatf("model out_flit[%0d]", o), out_flit[o], m_of[o]);
                check_output($sformatf("model out_tail[%0d]", o), 64'(out_tail[o]), 64'(m_ot[o]));
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ov <= '0;
            m_ot <= '0;
            for (int o = 0; o < NP; o++) begin
                m_of[o]   <= '0;
                m_own[o]  <= -1;
                m_ptr[o]  <= 0;
                m_bind[o] <= -1;
            end
        end else begin
            for (int o = 0; o < NP; o++) if (out_ready[o]) m_ov[o] <= 1'b0;
            for (int i = 0; i < NP; i++) begin
                if (in_valid[i] && m_rdy[i] && m_dst[i] >= 0) begin
                    m_ov[m_dst[i]] <= 1'b1;
                    m_of[m_dst[i]] <= in_flit[i];
                    m_ot[m_dst[i]] <= in_tail[i];
                    if (m_bind[i] >= 0) begin
                        if (in_tail[i]) begin
                            m_bind[i]        <= -1;
                            m_own[m_dst[i]]  <= -1;
                        end
                    end else begin
                        m_ptr[m_dst[i]] <= (i + 1) % NP;
                        if (!in_tail[i]) begin
                            m_bind[i]       <= m_dst[i];
                            m_own[m_dst[i]] <= i;
                        end
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        in_valid  = '0;
        in_head   = '0;
        in_tail   = '0;
        in_target = '0;
        in_flit   = '0;
    endtask

    task automatic apply_stimulus(input int i, input logic [63:0] f, input logic h,
                                  input logic t, input logic [2:0] tgt);
        in_valid[i]  = 1'b1;
        in_flit[i]   = f;
        in_head[i]   = h;
        in_tail[i]   = t;
        in_target[i] = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n0;
        int n1;
        rst       = 1'b1;
        out_ready = '1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset out_valid", 64'(out_valid), 64'h0);
        check_output("reset in_ready", 64'(in_ready), 64'h0);
        check_output("reset err_drop", 64'(err_drop), 64'h0);
        check_output("reset out_flit[0]", out_flit[0], 64'h0);
        check_output("reset out_tail", 64'(out_tail), 64'h0);
        step();
        rst = 1'b0;

        // 3-flit packet in0 -> o2
        apply_stimulus(0, 64'hA0, 1'b1, 1'b0, 3'd2);
        @(negedge clk);
        check_output("t1 head ready", 64'(in_ready[0]), 64'h1);
        step();
        apply_stimulus(0, 64'hA1, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        check_output("t1 out_flit A0", out_flit[2], 64'hA0);
        step();
        apply_stimulus(0, 64'hA2, 1'b0, 1'b1, 3'd0);
        @(negedge clk);
        check_output("t1 out_flit A1", out_flit[2], 64'hA1);
        step();
        clear_inputs();
        apply_stimulus(1, 64'hB9, 1'b1, 1'b1, 3'd2);
        @(negedge clk);
        check_output("t1 out_flit A2", out_flit[2], 64'hA2);
        check_output("t1 out_tail", 64'(out_tail[2]), 64'h1);
        check_output("t1 lock released", 64'(in_ready[1]), 64'h1);
        step();
        clear_inputs();

        // two inputs contend for o3 with single-flit packets
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(0, 64'h3000 + 64'(k), 1'b1, 1'b1, 3'd3);
            apply_stimulus(1, 64'h3100 + 64'(k), 1'b1, 1'b1, 3'd3);
            @(negedge clk);
            check_output("t2 alternate in0", 64'(in_ready[0]), 64'((k % 2) == 0));
            check_output("t2 alternate in1", 64'(in_ready[1]), 64'((k % 2) == 1));
            if (in_ready[0]) n0++;
            if (in_ready[1]) n1++;
            step();
        end
        clear_inputs();
        check_output("t2 in0 grants", 64'(n0), 64'd10);
        check_output("t2 in1 grants", 64'(n1), 64'd10);

        // backpressure on o1 mid-packet from in2
        apply_stimulus(2, 64'hC0, 1'b1, 1'b0, 3'd1);
        step();
        apply_stimulus(2, 64'hC1, 1'b0, 1'b0, 3'd0);
        step();
        apply_stimulus(2, 64'hC2, 1'b0, 1'b0, 3'd0);
        out_ready[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("t3 held flit", out_flit[1], 64'hC1);
            check_output("t3 owner stalled", 64'(in_ready[2]), 64'h0);
            step();
        end
        out_ready[1] = 1'b1;
        @(negedge clk);
        check_output("t3 owner resumes", 64'(in_ready[2]), 64'h1);
        step();
        apply_stimulus(2, 64'hC3, 1'b0, 1'b1, 3'd0);
        @(negedge clk);
        check_output("t3 out_flit C2", out_flit[1], 64'hC2);
        step();
        clear_inputs();
        @(negedge clk);
        check_output("t3 out_flit C3", out_flit[1], 64'hC3);
        step();

        // invalid target
        apply_stimulus(3, 64'hDEAD, 1'b1, 1'b0, 3'd7);
        @(negedge clk);
        check_output("t4 drop ready", 64'(in_ready[3]), 64'h1);
        check_output("t4 drop pulse", 64'(err_drop), 64'h08);
        step();
        clear_inputs();
        @(negedge clk);
        check_output("t4 pulse ends", 64'(err_drop), 64'h0);
        check_output("t4 nothing out", 64'(out_valid), 64'h0);
        step();

        // five inputs to five distinct outputs
        for (int i = 0; i < NP; i++)
            apply_stimulus(i, 64'h5000 + 64'(i), 1'b1, 1'b1, 3'((i + 1) % NP));
        @(negedge clk);
        check_output("t5 all ready", 64'(in_ready), 64'h1F);
        step();
        clear_inputs();
        @(negedge clk);
        check_output("t5 all valid", 64'(out_valid), 64'h1F);
        check_output("t5 out_flit[1]", out_flit[1], 64'h5000);
        check_output("t5 out_flit[0]", out_flit[0], 64'h5004);
        step();

        // reset in the middle of a packet
        apply_stimulus(4, 64'hE0, 1'b1, 1'b0, 3'd0);
        step();
        apply_stimulus(4, 64'hE1, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        check_output("t6 pre-reset valid", 64'(out_valid[0]), 64'h1);
        #1;
        rst = 1'b1;
        clear_inputs();
        #1;
        check_output("t6 reset out_valid", 64'(out_valid), 64'h0);
        check_output("t6 reset out_flit[0]", out_flit[0], 64'h0);
        check_output("t6 reset in_ready", 64'(in_ready), 64'h0);
        step();
        rst = 1'b0;
        apply_stimulus(1, 64'hF0, 1'b1, 1'b1, 3'd0);
        @(negedge clk);
        check_output("t6 regrant after reset", 64'(in_ready[1]), 64'h1);
        step();
        clear_inputs();
        @(negedge clk);
        check_output("t6 out_flit F0", out_flit[0], 64'hF0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
